// File: rtl/tdc_capture.sv
// tdc_capture: averages 2^AVG_LOG2 thermometer-decoded delay-line snapshots per measurement.
//
// Ports:
//   clk         system clock, all state on rising edge
//   rst         synchronous active-high reset
//   taps        raw delay-line snapshot (asynchronous to clk), bit 0 nearest launch point
//   start       single-cycle measurement request, honoured only when idle
//   busy        high while settling or accumulating
//   out_code    averaged leading-ones count of the last measurement
//   out_valid   out_code valid, held until out_ready
//   out_ready   consumer accept
//   bubble_err  sticky: a sample of the current/last measurement had a 1 above its first 0
module tdc_capture #(
  parameter int unsigned N_TAPS   = 16,
  parameter int unsigned AVG_LOG2 = 3,
  localparam int unsigned CW      = $clog2(N_TAPS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_TAPS-1:0] taps,
  input  logic              start,
  output logic              busy,
  output logic [CW-1:0]     out_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              bubble_err
);

  localparam int unsigned AW    = CW + AVG_LOG2;
  localparam int unsigned CNTW  = AVG_LOG2 + 1;
  localparam int unsigned NSAMP = 1 << AVG_LOG2;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StSettle = 2'd1;
  localparam logic [1:0] StAccum  = 2'd2;
  localparam logic [1:0] StDone   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [N_TAPS-1:0] sync1_q, sync2_q;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic [CW-1:0]     code_q, code_d;
  logic              bub_q, bub_d;

  logic [CW-1:0]     dec;
  logic              dec_bubble;
  logic              seen_zero;
  logic [AW-1:0]     acc_sum;

  // Leading-ones decode of the synchronised snapshot; any 1 after the first 0 is a bubble.
  always_comb begin
    dec        = '0;
    dec_bubble = 1'b0;
    seen_zero  = 1'b0;
    for (int i = 0; i < int'(N_TAPS); i++) begin
      if (!sync2_q[i]) begin
        seen_zero = 1'b1;
      end else if (seen_zero) begin
        dec_bubble = 1'b1;
      end else begin
        dec = dec + 1'b1;
      end
    end
  end

  assign acc_sum = acc_q + AW'(dec);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    code_d  = code_q;
    bub_d   = bub_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StSettle;
          cnt_d   = '0;
          acc_d   = '0;
          bub_d   = 1'b0;
        end
      end
      StSettle: begin
        // Two cycles let the synchroniser flush stale snapshots.
        if (cnt_q == CNTW'(1)) begin
          state_d = StAccum;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StAccum: begin
        acc_d = acc_sum;
        cnt_d = cnt_q + 1'b1;
        if (dec_bubble) begin
          bub_d = 1'b1;
        end
        if (cnt_q == CNTW'(NSAMP - 1)) begin
          state_d = StDone;
          // Include this cycle's sample; truncating divide.
          code_d  = CW'(acc_sum >> AVG_LOG2);
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      sync1_q <= '0;
      sync2_q <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      code_q  <= '0;
      bub_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= taps;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      code_q  <= code_d;
      bub_q   <= bub_d;
    end
  end

  assign busy       = (state_q == StSettle) || (state_q == StAccum);
  assign out_valid  = (state_q == StDone);
  assign out_code   = code_q;
  assign bubble_err = bub_q;

endmodule

// File: tb/tb_tdc_capture.sv
// tb_tdc_capture: directed stimulus for tdc_capture with a transaction-level reference model.
module tb_tdc_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        out_ready;
  logic [15:0] taps;
  logic        busy;
  logic        out_valid;
  logic        bubble_err;
  logic [4:0]  out_code;

  tdc_capture #(
    .N_TAPS  (16),
    .AVG_LOG2(3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .taps      (taps),
    .start     (start),
    .busy      (busy),
    .out_code  (out_code),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bubble_err(bubble_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int lead_ones(input logic [15:0] v);
    int n = 0;
    while (n < 16 && v[n]) n++;
    return n;
  endfunction

  // A clean thermometer word is exactly 2^lead - 1.
  function automatic bit is_bubble(input logic [15:0] v);
    return v != 16'((32'd1 << lead_ones(v)) - 32'd1);
  endfunction

  // Reference model: a measurement accepted at edge k averages the taps seen at edges
  // k+1..k+8 (two-flop delay, sample added at edges k+3..k+10) and completes at edge k+10.
  int          e = 0;
  int          m_k = 0;
  int          m_code = 0;
  bit          m_init = 0;
  bit          m_run = 0;
  bit          m_valid = 0;
  bit          m_bub = 0;
  logic [15:0] hist [0:4095];

  initial begin : model
    int last;
    int sum;
    forever begin
      @(posedge clk);
      hist[e] = taps;
      if (rst) begin
        m_init  = 1;
        m_run   = 0;
        m_valid = 0;
        m_code  = 0;
        m_bub   = 0;
      end else if (m_run) begin
        last = (e - 2 < m_k + 8) ? e - 2 : m_k + 8;
        for (int j = m_k + 1; j <= last; j++) begin
          if (is_bubble(hist[j])) m_bub = 1;
        end
        if (e - m_k == 10) begin
          sum = 0;
          for (int j = m_k + 1; j <= m_k + 8; j++) sum += lead_ones(hist[j]);
          m_code  = sum / 8;
          m_run   = 0;
          m_valid = 1;
        end
      end else if (m_valid) begin
        if (out_ready) m_valid = 0;
      end else if (start) begin
        m_run = 1;
        m_k   = e;
        m_bub = 0;
      end
      if (e < 4095) e++;
      @(negedge clk);
      if (m_init) begin
        chk("busy", int'(busy), int'(m_run));
        chk("out_valid", int'(out_valid), int'(m_valid));
        chk("out_code", int'(out_code), m_code);
        chk("bubble_err", int'(bubble_err), int'(m_bub));
      end
    end
  end

  // Runs one measurement with taps alternating a,b,a,... starting at the start edge.
  task automatic run_meas(input logic [15:0] a, input logic [15:0] b, input int exp_code,
                          input int exp_bub, input bit ack, input string name);
    int n;
    int nb;
    bit got;
    taps  = a;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n   = 0;
    nb  = 0;
    got = 0;
    while (!got && n < 40) begin
      taps = (n % 2 == 0) ? b : a;
      @(negedge clk);
      if (busy) nb++;
      if (out_valid) begin
        got = 1;
      end else begin
        @(posedge clk);
        #1 n++;
      end
    end
    // Valid appears right after edge k+10, so edge k+11 is the first to see it.
    chk({name, "_latency"}, got ? n : -1, 10);
    chk({name, "_busy_cycles"}, nb, 10);
    chk({name, "_code"}, int'(out_code), exp_code);
    chk({name, "_bubble"}, int'(bubble_err), exp_bub);
    chk({name, "_model_code"}, m_code, exp_code);
    if (ack) begin
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
    end
  endtask

  initial begin : stim
    rst       = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;
    taps      = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    run_meas(16'h00FF, 16'h00FF, 8, 0, 1'b1, "ff");
    run_meas(16'hFFFF, 16'hFFFF, 16, 0, 1'b1, "all_ones");
    run_meas(16'h0000, 16'h0000, 0, 0, 1'b1, "zero");
    run_meas(16'h0001, 16'h0001, 1, 0, 1'b1, "one");
    run_meas(16'h00F7, 16'h00F7, 3, 1, 1'b1, "bubble");
    run_meas(16'h000F, 16'h000F, 4, 0, 1'b1, "bubble_clear");
    run_meas(16'h000F, 16'h001F, 4, 0, 1'b0, "alt");

    // Hold in DONE with out_ready low; start pulses must be ignored.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 start = (i == 1);
    end
    @(negedge clk);
    chk("hold_valid", int'(out_valid), 1);
    chk("hold_code", int'(out_code), 4);
    chk("hold_busy", int'(busy), 0);
    // Handshake with start also high: back to IDLE, no new measurement.
    out_ready = 1'b1;
    start     = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("ack_valid", int'(out_valid), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_new_meas", int'(busy), 0);
    end
    chk("code_retained", int'(out_code), 4);

    // Reset during the 4th ACCUM cycle (ACCUM occupies cycles after edges k+2..k+9).
    taps  = 16'h0A1F;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_code", int'(out_code), 0);
    chk("rst_bubble", int'(bubble_err), 0);

    run_meas(16'h00FF, 16'h00FF, 8, 0, 1'b1, "after_rst");
    repeat (3) @(posedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
